// File: rtl/spu_wen_pkg.sv
// Shared constants and types for the multi-channel SPU MA write-enable block.
package spu_wen_pkg;

  localparam logic [3:0] RTNTYP_LOAD = 4'b0010;

  localparam logic [5:0] RQ_LD = 6'b001001;
  localparam logic [5:0] RQ_ST = 6'b001011;

  localparam logic [7:0] SZ_LD = 8'b00000100;
  localparam logic [7:0] SZ_ST = 8'b00010000;

  // Channel index doubles as the LSU strand tid.
  typedef logic [1:0] chan_t;

endpackage

// File: rtl/spu_wen_stack_cntr.sv
// One channel's outstanding-store counter. Define SPU_WEN_CNTR_CHK_EN to
// saturate at both ends and latch a sticky over/underflow flag.
module spu_wen_stack_cntr #(
  parameter int CNTW = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  input  logic [1:0] dec_i,
  output logic       stacks_ok_o,
  output logic       cntr_err_o
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW:0]   sum;

  // Increment and decrement are folded into one update; the extra top bit
  // flags a result outside 0..CNT_MAX.
  assign sum = {1'b0, cnt_q} + {{CNTW{1'b0}}, inc_i} - {{(CNTW-1){1'b0}}, dec_i};

`ifdef SPU_WEN_CNTR_CHK_EN
  logic err_q, err_d;

  // A carry out with a nonzero decrement can only be a borrow (underflow).
  function automatic logic [CNTW-1:0] sat_cnt(input logic [CNTW:0] s, input logic dec_nz);
    if (!s[CNTW]) return s[CNTW-1:0];
    return dec_nz ? '0 : CNT_MAX;
  endfunction

  assign cnt_d = sat_cnt(sum, |dec_i);
  assign err_d = err_q | sum[CNTW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign cntr_err_o = err_q;
`else
  logic unused_carry;

  assign unused_carry = sum[CNTW];
  assign cnt_d        = sum[CNTW-1:0];
  assign cntr_err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign stacks_ok_o = (cnt_q == '0);

endmodule

// File: rtl/spu_wen_mc.sv
// Multi-channel SPU MA write-enable, ack, store-counter, L2 error and PCX
// header block. Optional counter checking: SPU_WEN_CNTR_CHK_EN.
module spu_wen_mc
  import spu_wen_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int CNTW = 6
) (
  input  logic            rclk,
  input  logic            arst_l,
  input  logic            se,
  input  logic [2:0]      cpuid,
  input  logic [NCH-1:0]  ldreq,
  input  logic [NCH-1:0]  streq,
  input  logic            ld_ackvld,
  input  logic            ld_asop,
  input  logic [1:0]      ld_ack_tid,
  input  logic            st_ackvld,
  input  logic            st_asop,
  input  logic [1:0]      st_ack_tid,
  input  logic            vload_vld,
  input  logic [3:0]      vload_rtntyp,
  input  logic [1:0]      vload_tid,
  input  logic [1:0]      l2_err,
  input  logic [1:0]      strm_ack_cmplt,
  input  logic [1:0]      strm_tid,
  input  logic [NCH-1:0]  rstln,
  input  logic [NCH-1:0]  done,
  input  logic [NCH-1:0]  uncerr_rst,
  output logic [NCH-1:0]  maln_wen,
  output logic [NCH-1:0]  vld_maln,
  output logic [NCH-1:0]  mald_ack,
  output logic [NCH-1:0]  mast_ack,
  output logic            ldst_pcx_vld,
  output logic [NCH-1:0]  stacks_ok,
  output logic [NCH-1:0]  unc_err_pulse,
  output logic [NCH-1:0]  unc_err,
  output logic [NCH-1:0]  cor_err,
  output logic [18:0]     pckt_req,
  output logic [NCH-1:0]  cntr_err
);

  logic unused_se;
  assign unused_se = se;

  logic [NCH-1:0] vld_maln_q, vld_maln_d;
  logic [NCH-1:0] unc_err_q, unc_err_d;
  logic [NCH-1:0] wen_q;
  logic [1:0]     err_q;
  chan_t          st_ack_tid_q, ld_ack_tid_q;
  logic           st_asop_q, ld_asop_q;
  logic [NCH-1:0] streq_d1_q, streq_d2_q;
  logic           st_ackvld_q;
  logic [1:0]     strm_cmplt_q;
  chan_t          strm_tid_q;

  // Sticky bits: clear requests win over a simultaneous set.
  assign vld_maln_d = (vld_maln_q | maln_wen) & ~(rstln | done);
  assign unc_err_d  = (unc_err_q | unc_err_pulse) & ~uncerr_rst;

  // Stage boundary: everything below is one cycle behind its inputs.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      vld_maln_q   <= '0;
      unc_err_q    <= '0;
      wen_q        <= '0;
      err_q        <= '0;
      st_ack_tid_q <= '0;
      ld_ack_tid_q <= '0;
      st_asop_q    <= 1'b0;
      ld_asop_q    <= 1'b0;
      streq_d1_q   <= '0;
      streq_d2_q   <= '0;
      st_ackvld_q  <= 1'b0;
      strm_cmplt_q <= '0;
      strm_tid_q   <= '0;
    end else begin
      vld_maln_q   <= vld_maln_d;
      unc_err_q    <= unc_err_d;
      wen_q        <= maln_wen;
      err_q        <= l2_err;
      st_ack_tid_q <= st_ack_tid;
      ld_ack_tid_q <= ld_ack_tid;
      st_asop_q    <= st_asop;
      ld_asop_q    <= ld_asop;
      streq_d1_q   <= streq;
      streq_d2_q   <= streq_d1_q;
      st_ackvld_q  <= st_ackvld;
      strm_cmplt_q <= strm_ack_cmplt;
      strm_tid_q   <= strm_tid;
    end
  end

  assign vld_maln = vld_maln_q;
  assign unc_err  = unc_err_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam chan_t CH = chan_t'(c);

    logic       inc;
    logic [1:0] dec;

    assign maln_wen[c] = vload_vld & (vload_rtntyp == RTNTYP_LOAD) & (vload_tid == CH);

    assign mast_ack[c] = st_ackvld & st_asop_q & (st_ack_tid_q == CH) & streq[c];
    assign mald_ack[c] = ld_ackvld & ld_asop_q & (ld_ack_tid_q == CH) & ldreq[c] & ~streq[c];

    assign unc_err_pulse[c] = err_q[1] & wen_q[c];
    assign cor_err[c]       = ~err_q[1] & err_q[0] & wen_q[c];

    assign inc = streq_d2_q[c] & st_ackvld_q;
    assign dec = (strm_tid_q == CH) ? strm_cmplt_q : 2'b00;

    spu_wen_stack_cntr #(
      .CNTW (CNTW)
    ) u_cntr (
      .clk_i       (rclk),
      .rst_ni      (arst_l),
      .inc_i       (inc),
      .dec_i       (dec),
      .stacks_ok_o (stacks_ok[c]),
      .cntr_err_o  (cntr_err[c])
    );
  end

  // Requests are one-hot across {streq, ldreq}, so OR-ing indices encodes the tid.
  always_comb begin
    logic [NCH-1:0] req_vec;
    chan_t          tid;
    req_vec = streq | ldreq;
    tid     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (req_vec[i]) tid = tid | chan_t'(i);
    end
    ldst_pcx_vld = |req_vec;
    if (|streq) pckt_req = {RQ_ST, cpuid, tid, SZ_ST};
    else        pckt_req = {RQ_LD, cpuid, tid, SZ_LD};
  end

endmodule

// File: doc/spu_wen_mc.md
# spu_wen_mc

Multi-channel successor to the SPU MA write-enable block. It serves `NCH` modular-arithmetic channels, one per strand tid, instead of a single hard-wired tid 0. For each channel it generates the MA line-buffer write enable and valid bit, load/store ack strobes, outstanding-store counters and sticky L2 error status. It also builds the shared PCX request header, with the requesting tid encoded in it. It sits between the SPU MA control/load sequencers and the LSU interface.

## Interface
Parameters:
- `NCH`, 2: number of channels, 1..4; channel index equals the LSU tid.
- `CNTW`, 6: width of each outstanding-store counter.

Ports:
- `rclk`  in  1  clock.
- `arst_l`  in  1  reset, asynchronous, active-low.
- `se`  in  1  scan enable; no functional effect.
- `cpuid`  in  3  core id placed in the request header.
- `ldreq`  in  NCH  per-channel load request, level.
- `streq`  in  NCH  per-channel store request, level.
  - At most one bit across `{streq, ldreq}` may be set in any cycle (upstream arbiter guarantee).
- `ld_ackvld`, `ld_asop`  in  1 each  LSU load ack valid / ASI-op qualifier.
- `ld_ack_tid`  in  2  LSU load ack tid.
- `st_ackvld`, `st_asop`  in  1 each  LSU store ack valid / ASI-op qualifier.
- `st_ack_tid`  in  2  LSU store ack tid.
- `vload_vld`  in  1  L2 load-return valid.
- `vload_rtntyp`  in  4  L2 return type.
- `vload_tid`  in  2  L2 load-return tid.
- `l2_err`  in  2  L2 error for the return: [1] uncorrectable, [0] correctable.
- `strm_ack_cmplt`  in  2  number of stores completed by L2 this cycle (0..2).
- `strm_tid`  in  2  channel for `strm_ack_cmplt`.
- `rstln`, `done`, `uncerr_rst`  in  NCH each  per-channel clear requests.
- `maln_wen`  out  NCH  line-buffer write enable.
- `vld_maln`  out  NCH  line valid.
- `mald_ack`, `mast_ack`  out  NCH each  load/store ack strobes.
- `ldst_pcx_vld`  out  1  OR of all `ldreq` and `streq` bits.
- `stacks_ok`  out  NCH  channel has no outstanding stores.
- `unc_err_pulse`, `unc_err`, `cor_err`  out  NCH each  L2 error status.
- `pckt_req`  out  19  PCX request header bits [122:104].
- `cntr_err`  out  NCH  counter over/underflow, sticky; present only with the macro.

## Operation
- Load return:
  - `maln_wen[c]` = `vload_vld` & `vload_rtntyp`==4'b0010 & `vload_tid`==c.
  - This output is combinational.
- Line valid: `vld_maln[c]` sets the cycle after `maln_wen[c]`.
  - It clears the cycle after `rstln[c]`, `done[c]`, or reset.
  - Clear wins over a simultaneous set.
- Acks:
  - `ack_tid` and `asop` are registered; the LSU presents them one cycle ahead of `ackvld`.
  - `mast_ack[c]` = `st_ackvld` & `st_asop_q` & `st_ack_tid_q`==c & `streq[c]`.
  - `mald_ack[c]` = `ld_ackvld` & `ld_asop_q` & `ld_ack_tid_q`==c & `ldreq[c]` & ~`streq[c]`.
- Errors:
  - `l2_err` and `maln_wen` are registered together.
  - `unc_err_pulse[c]` = `err_q[1]` & `wen_q[c]`.
  - `cor_err[c]` = ~`err_q[1]` & `err_q[0]` & `wen_q[c]`.
  - `unc_err[c]` is sticky. It sets the cycle after the pulse and clears on `uncerr_rst[c]` or reset; clear wins.
- Store counter, per channel:
  - Increment when `streq[c]` delayed two cycles AND `st_ackvld` delayed one cycle are both high.
  - Decrement by registered `strm_ack_cmplt` when registered `strm_tid`==c.
  - Next value = cnt + inc − dec, computed in `CNTW`+1 bits.
  - Simultaneous increment and decrement are summed in one update.
  - `stacks_ok[c]` = (cnt==0).
- Header: `pckt_req` = {rqtype, `cpuid`, tid[1:0], 8-bit size}.
  - Store: rqtype 6'b001011, size 8'b00010000.
  - Otherwise (load): rqtype 6'b001001, size 8'b00000100.
  - tid is the encoded index of the active request bit; 0 if none.
- `NCH`<4: inputs with tid ≥ `NCH` are ignored and affect no channel.

## Timing
- Reset values: all registered outputs are 0, all counters are 0, `stacks_ok` is all 1s.
- Reset mid-operation discards counts and sticky bits immediately (asynchronous).
- Latencies:
  - `maln_wen`, acks, `ldst_pcx_vld`, `pckt_req`: 0 cycles.
  - `vld_maln`: 1 cycle after `maln_wen`.
  - Error pulses: 1 cycle after the load return.
  - Counter increment: visible 3 cycles after the `streq` that was acked.
  - Counter decrement: visible 2 cycles after `strm_ack_cmplt`.

## Configuration
- `SPU_WEN_CNTR_CHK_EN` defined:
  - The counter saturates at 2^`CNTW`−1 and at 0.
  - An attempted overflow or underflow sets sticky `cntr_err[c]`, cleared only by reset.
- `SPU_WEN_CNTR_CHK_EN` not defined:
  - The counter wraps modulo 2^`CNTW`.
  - `cntr_err` is tied to 0.

## Structure
- Package `spu_wen_pkg` holds:
  - `RTNTYP_LOAD` = 4'b0010.
  - `RQ_LD` / `RQ_ST` opcodes.
  - `SZ_LD` / `SZ_ST` size codes.
  - The channel-index typedef.
- Sub-module `spu_wen_stack_cntr` holds one channel's counter, `stacks_ok`, and the checker; it is instantiated `NCH` times via generate.

## Test plan
- Load return with `vload_tid`=1, rtntyp 0010 and `l2_err`=2'b10:
  - `maln_wen[1]`=1 in the same cycle.
  - The next cycle: `vld_maln[1]`=1, `unc_err_pulse[1]`=1, and `unc_err[1]` sticks until `uncerr_rst[1]`.
- `streq[0]` held, with st tid 0 and asop=1 one cycle before `st_ackvld`:
  - `mast_ack[0]`=1.
  - `pckt_req` = {001011, cpuid, 00, 00010000}.
  - Counter 0 reaches 1 three cycles later and `stacks_ok[0]` drops.
- Counter 1 at 3, `strm_ack_cmplt`=2 with `strm_tid`=1, and a simultaneous increment: counter 1 = 2 two cycles later.
- Counter at 0 with `strm_ack_cmplt`=1:
  - With the macro: counter stays 0 and `cntr_err`=1.
  - Without it: counter = 63.
- `maln_wen[0]` and `done[0]` in the same cycle: `vld_maln[0]` stays 0.
- `arst_l` low mid-count: all counters 0 and `stacks_ok` all 1 immediately, without waiting for a clock edge.
